// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: one Rx sample per Clk edge, MSB-first payload, optional even parity, 1..4 stop bits.
// Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN.
module uart_rx_deserializer #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_BIT = 1,
    parameter int STOP_BITS  = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Rx,
    input  logic                 Loopback,
    input  logic                 Tx_Loop,
    input  logic                 FIFO_Ready,
    output logic                 RTS,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Rx_Valid,
    output logic [2:0]           Rx_Error,
    output logic                 Busy
);

    // state  | meaning
    // IDLE   | line idle, waiting for a 0 start bit
    // DATA   | shifting in DATA_BITS payload bits, MSB first
    // PARITY | sampling the even-parity bit
    // STOP   | sampling STOP_BITS stop bits, publishing on the last one
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam int CNT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic                 ones_seen_q, ones_seen_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic [2:0]           rx_err_q, rx_err_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 ser;

    assign ser = Loopback ? Tx_Loop : Rx;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        par_err_d   = par_err_q;
        frm_err_d   = frm_err_q;
        ones_seen_d = ones_seen_q;
        rx_data_d   = rx_data_q;
        rx_err_d    = rx_err_q;
        rx_valid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!ser) begin
                    state_d     = DATA;
                    cnt_d       = '0;
                    par_err_d   = 1'b0;
                    frm_err_d   = 1'b0;
                    ones_seen_d = 1'b0;
                end
            end
            DATA: begin
                shift_d     = {shift_q[DATA_BITS-2:0], ser};
                ones_seen_d = ones_seen_q | ser;
                if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
                    cnt_d   = '0;
                    state_d = (PARITY_BIT != 0) ? PARITY : STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                par_err_d   = ser ^ (^shift_q);
                ones_seen_d = ones_seen_q | ser;
                cnt_d       = '0;
                state_d     = STOP;
            end
            STOP: begin
                frm_err_d   = frm_err_q | ~ser;
                ones_seen_d = ones_seen_q | ser;
                if (cnt_q == CNT_W'(STOP_BITS - 1)) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    rx_valid_d = 1'b1;
                    rx_data_d  = shift_q;
                    rx_err_d   = {frm_err_q | ~ser, par_err_q, 1'b0};
`ifdef UART_RX_BREAK_DETECT_EN
                    // A frame with no 1 anywhere is a line break, not a bad character.
                    if (!(ones_seen_q | ser)) begin
                        rx_err_d = 3'b001;
                    end
`else
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            par_err_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            ones_seen_q <= 1'b0;
            rx_data_q   <= '0;
            rx_err_q    <= 3'b000;
            rx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            par_err_q   <= par_err_d;
            frm_err_q   <= frm_err_d;
            ones_seen_q <= ones_seen_d;
            rx_data_q   <= rx_data_d;
            rx_err_q    <= rx_err_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

    assign Rx_Data  = rx_data_q;
    assign Rx_Error = rx_err_q;
    assign Rx_Valid = rx_valid_q;
    assign Busy     = (state_q != IDLE);
    assign RTS      = (state_q == IDLE) && FIFO_Ready;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: table of whole frames plus hand sequences
// for reset mid-frame, back-to-back frames and a Loopback switch inside a frame.
module tb_uart_rx_deserializer;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Rx;
    logic       Loopback;
    logic       Tx_Loop;
    logic       FIFO_Ready;
    logic       RTS;
    logic [7:0] Rx_Data;
    logic       Rx_Valid;
    logic [2:0] Rx_Error;
    logic       Busy;

    int total = 0;
    int bad   = 0;

    uart_rx_deserializer #(
        .DATA_BITS (8),
        .PARITY_BIT(1),
        .STOP_BITS (2)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Rx        (Rx),
        .Loopback  (Loopback),
        .Tx_Loop   (Tx_Loop),
        .FIFO_Ready(FIFO_Ready),
        .RTS       (RTS),
        .Rx_Data   (Rx_Data),
        .Rx_Valid  (Rx_Valid),
        .Rx_Error  (Rx_Error),
        .Busy      (Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [11:0] bits;
        logic        lb;
        logic [7:0]  exp_data;
        logic [2:0]  exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    // Drives the 12 frame bits (bit 11 first) on the selected source; vedge is the
    // index of the first sampling edge after which Rx_Valid was seen high, or -1.
    task automatic send_frame(input logic [11:0] bits, input logic lb, output int vedge);
        vedge = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            Loopback = lb;
            if (lb) begin
                Tx_Loop = bits[11-i];
                Rx      = 1'b0;
            end else begin
                Rx      = bits[11-i];
                Tx_Loop = 1'b0;
            end
            @(posedge Clk);
            #1;
            if (Rx_Valid && vedge < 0) vedge = i;
        end
    endtask

    task automatic idle_line(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            Loopback = 1'b0;
            Rx       = 1'b1;
            Tx_Loop  = 1'b1;
            @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        int          ve;
        int          vcount;
        logic [11:0] fb;
        logic        b;

        vecs[0] = '{{1'b0, 8'hA5, 1'b0, 2'b11}, 1'b0, 8'hA5, 3'b000};
        vecs[1] = '{{1'b0, 8'hAA, 1'b1, 2'b11}, 1'b0, 8'hAA, 3'b010};
        vecs[2] = '{{1'b0, 8'hAA, 1'b0, 2'b00}, 1'b0, 8'hAA, 3'b100};
`ifdef UART_RX_BREAK_DETECT_EN
        vecs[3] = '{12'h000, 1'b0, 8'h00, 3'b001};
`else
        vecs[3] = '{12'h000, 1'b0, 8'h00, 3'b100};
`endif
        vecs[4] = '{{1'b0, 8'h3C, 1'b0, 2'b11}, 1'b1, 8'h3C, 3'b000};
        vecs[5] = '{{1'b0, 8'h01, 1'b1, 2'b11}, 1'b0, 8'h01, 3'b000};
        vecs[6] = '{{1'b0, 8'hFF, 1'b0, 2'b10}, 1'b0, 8'hFF, 3'b100};
        vecs[7] = '{{1'b0, 8'h80, 1'b0, 2'b01}, 1'b0, 8'h80, 3'b110};

        Rst        = 1'b0;
        Rx         = 1'b1;
        Loopback   = 1'b0;
        Tx_Loop    = 1'b1;
        FIFO_Ready = 1'b1;
        #12;
        chk("rst_data", 32'(Rx_Data), 32'h00);
        chk("rst_err", 32'(Rx_Error), 32'h0);
        chk("rst_valid", 32'(Rx_Valid), 32'h0);
        chk("rst_busy", 32'(Busy), 32'h0);
        chk("rst_rts_ready", 32'(RTS), 32'h1);
        FIFO_Ready = 1'b0;
        #1;
        chk("rst_rts_notready", 32'(RTS), 32'h0);
        FIFO_Ready = 1'b1;
        @(negedge Clk);
        Rst = 1'b1;
        idle_line(2);

        for (int v = 0; v < 8; v++) begin
            send_frame(vecs[v].bits, vecs[v].lb, ve);
            chk($sformatf("v%0d_latency", v), 32'(ve), 32'd11);
            chk($sformatf("v%0d_data", v), 32'(Rx_Data), 32'(vecs[v].exp_data));
            chk($sformatf("v%0d_err", v), 32'(Rx_Error), 32'(vecs[v].exp_err));
            idle_line(1);
            chk($sformatf("v%0d_valid_drop", v), 32'(Rx_Valid), 32'h0);
            chk($sformatf("v%0d_busy_after", v), 32'(Busy), 32'h0);
            idle_line(2);
            chk($sformatf("v%0d_hold_data", v), 32'(Rx_Data), 32'(vecs[v].exp_data));
            chk($sformatf("v%0d_hold_err", v), 32'(Rx_Error), 32'(vecs[v].exp_err));
        end

        // Partial frame: start bit plus five 1s, then reset.
        fb = {1'b0, 8'hFF, 1'b0, 2'b11};
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            Rx = fb[11-i];
            @(posedge Clk);
            #1;
        end
        chk("mid_busy", 32'(Busy), 32'h1);
        chk("mid_rts", 32'(RTS), 32'h0);
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        chk("mrst_busy", 32'(Busy), 32'h0);
        chk("mrst_valid", 32'(Rx_Valid), 32'h0);
        chk("mrst_data", 32'(Rx_Data), 32'h00);
        chk("mrst_err", 32'(Rx_Error), 32'h0);
        chk("mrst_rts", 32'(RTS), 32'h1);
        @(negedge Clk);
        Rst    = 1'b1;
        vcount = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge Clk);
            Rx = 1'b1;
            @(posedge Clk);
            #1;
            if (Rx_Valid || Busy) vcount++;
        end
        chk("mrst_no_partial", 32'(vcount), 32'd0);
        send_frame({1'b0, 8'h01, 1'b1, 2'b11}, 1'b0, ve);
        chk("post_rst_latency", 32'(ve), 32'd11);
        chk("post_rst_data", 32'(Rx_Data), 32'h01);
        chk("post_rst_err", 32'(Rx_Error), 32'h0);
        idle_line(2);

        // Back-to-back frames with the FIFO not ready: Rx_Valid still fires.
        FIFO_Ready = 1'b0;
        send_frame({1'b0, 8'hA5, 1'b0, 2'b11}, 1'b0, ve);
        chk("b2b0_latency", 32'(ve), 32'd11);
        chk("b2b0_data", 32'(Rx_Data), 32'hA5);
        send_frame({1'b0, 8'h3C, 1'b1, 2'b11}, 1'b0, ve);
        chk("b2b1_latency", 32'(ve), 32'd11);
        chk("b2b1_data", 32'(Rx_Data), 32'h3C);
        chk("b2b1_err", 32'(Rx_Error), 32'h2);
        idle_line(1);
        chk("b2b_rts_notready", 32'(RTS), 32'h0);
        FIFO_Ready = 1'b1;
        #1;
        chk("b2b_rts_ready", 32'(RTS), 32'h1);

        // Loopback switched on after the 5th data bit; the unselected line carries the inverse.
        fb = {1'b0, 8'h5A, 1'b0, 2'b11};
        ve = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            b        = fb[11-i];
            Loopback = (i >= 6);
            if (i >= 6) begin
                Tx_Loop = b;
                Rx      = ~b;
            end else begin
                Rx      = b;
                Tx_Loop = ~b;
            end
            @(posedge Clk);
            #1;
            if (Rx_Valid && ve < 0) ve = i;
        end
        chk("lbsw_latency", 32'(ve), 32'd11);
        chk("lbsw_data", 32'(Rx_Data), 32'h5A);
        chk("lbsw_err", 32'(Rx_Error), 32'h0);
        idle_line(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
